// File: rtl/mux_stream_if.sv
// Stream bundle for mux_stream: N flattened input channels and one registered output.
interface mux_stream_if #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8
) ();
  localparam int N = 2 ** SELECT_LINES;

  logic [SELECT_LINES-1:0] select;
  logic [DATA_WIDTH*N-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last;
  logic [N-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_last;
  logic [SELECT_LINES-1:0] out_channel;
  logic                    out_ready;

  modport master (
    output select, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_channel
  );

  modport slave (
    input  select, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_channel
  );
endinterface

// File: rtl/mux_stream.sv
// Packet-aware N-to-1 stream mux with one output register stage.
// Grant comes from select (MODE 0) or round-robin (MODE 1) and is held until the packet's last beat.
module mux_stream #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int MODE         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_stream_if.slave bus
);
  localparam int unsigned N = 2 ** SELECT_LINES;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SELECT_LINES-1:0] r_lock_ch, w_lock_ch_nxt;
  logic [SELECT_LINES-1:0] r_ptr, w_ptr_nxt;
  logic [SELECT_LINES-1:0] w_grant;
  logic                    w_grant_vld;
  logic                    w_can_load;
  logic                    w_xfer;
  logic                    w_last;
  logic [DATA_WIDTH-1:0]   w_in_word;

  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [SELECT_LINES-1:0] r_out_channel;

  // Round-robin: iterate farthest-first so the nearest valid channel after r_ptr wins.
  always_comb begin
    w_grant     = r_lock_ch;
    w_grant_vld = 1'b0;
    if (r_state == S_LOCKED) begin
      w_grant     = r_lock_ch;
      w_grant_vld = 1'b1;
    end else if (MODE == 0) begin
      w_grant     = bus.select;
      w_grant_vld = bus.in_valid[bus.select];
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        if (bus.in_valid[r_ptr + SELECT_LINES'(k)]) begin
          w_grant     = r_ptr + SELECT_LINES'(k);
          w_grant_vld = 1'b1;
        end
      end
    end
  end

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_xfer     = rst_n && w_grant_vld && w_can_load && bus.in_valid[w_grant];
  assign w_last     = bus.in_last[w_grant];
  assign w_in_word  = bus.in_data[w_grant*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    bus.in_ready = '0;
    if (rst_n && w_grant_vld && w_can_load) bus.in_ready[w_grant] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    w_ptr_nxt     = r_ptr;
    if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (MODE == 1) w_ptr_nxt = w_grant;
          if (!w_last) begin
            w_state_nxt   = S_LOCKED;
            w_lock_ch_nxt = w_grant;
          end
        end
        S_LOCKED: if (w_last) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lock_ch <= '0;
      r_ptr     <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_channel <= '0;
    end else if (w_xfer) begin
      r_out_data    <= w_in_word;
      r_out_valid   <= 1'b1;
      r_out_last    <= w_last;
      r_out_channel <= w_grant;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign bus.out_channel = r_out_channel;
endmodule
